// File: rtl/mix_freq_axil_pkg.sv
// mix_freq_axil_pkg: register map, CTRL bit positions, response codes and FSM state types
// shared by the mixer-frequency AXI-Lite slave and its write-path FSM.
package mix_freq_axil_pkg;

    localparam logic [2:0] FREQ_WORD = 3'd0;
    localparam logic [2:0] BIN_ADDR  = 3'd1;
    localparam logic [2:0] CTRL      = 3'd2;
    localparam logic [2:0] SCRATCH   = 3'd3;
    localparam logic [2:0] COMMIT    = 3'd4;

    localparam int CTRL_AUTO_INC = 0;
    localparam int CTRL_MIX_EN   = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_VALID} rd_state_e;

    function automatic logic [31:0] apply_strb(input logic [31:0] cur, input logic [31:0] nxt,
                                               input logic [3:0] strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) res[8*i +: 8] = strb[i] ? nxt[8*i +: 8] : cur[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/mix_freq_axil_wr_fsm.sv
// mix_freq_axil_wr_fsm: buffers AW and W independently, issues register writes or a
// frequency-table transfer for COMMIT, and returns the B response once the action is done.
module mix_freq_axil_wr_fsm
    import mix_freq_axil_pkg::*;
#(
    parameter int BIN_AW = 11
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [2:0]        awidx_i,
    input  logic              awvalid_i,
    output logic              awready_o,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        wstrb_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    output logic [1:0]        bresp_o,
    output logic              bvalid_o,
    input  logic              bready_i,
    input  logic [BIN_AW-1:0] bin_addr_i,
    input  logic [31:0]       freq_word_i,
    output logic              fwr_valid_o,
    input  logic              fwr_ready_i,
    output logic [BIN_AW-1:0] fwr_addr_o,
    output logic [31:0]       fwr_data_o,
    output logic              reg_we_o,
    output logic [2:0]        reg_idx_o,
    output logic [31:0]       reg_wdata_o,
    output logic [3:0]        reg_wstrb_o,
    output logic              bin_inc_o
);

    wr_state_e         state_q;
    logic              aw_held_q, w_held_q, awready_q, wready_q, bvalid_q, fvalid_q;
    logic [2:0]        idx_q;
    logic [31:0]       wdata_q, fdata_q;
    logic [3:0]        wstrb_q;
    logic [1:0]        bresp_q;
    logic [BIN_AW-1:0] faddr_q;
    logic              both, fire, aw_hs, w_hs;

    assign both  = state_q == W_IDLE && aw_held_q && w_held_q;
    assign fire  = idx_q == COMMIT && wstrb_q[0] && wdata_q[0];
    assign aw_hs = awready_q && awvalid_i;
    assign w_hs  = wready_q && wvalid_i;

    assign reg_we_o    = both && idx_q < COMMIT;
    assign reg_idx_o   = idx_q;
    assign reg_wdata_o = wdata_q;
    assign reg_wstrb_o = wstrb_q;
    assign bin_inc_o   = state_q == W_COMMIT && fwr_ready_i;

    assign awready_o   = awready_q;
    assign wready_o    = wready_q;
    assign bvalid_o    = bvalid_q;
    assign bresp_o     = bresp_q;
    assign fwr_valid_o = fvalid_q;
    assign fwr_addr_o  = faddr_q;
    assign fwr_data_o  = fdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            fvalid_q  <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            faddr_q   <= '0;
            fdata_q   <= '0;
        end else begin
            case (state_q)
                W_IDLE: begin
                    if (both) begin
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        if (fire) begin
                            fvalid_q <= 1'b1;
                            faddr_q  <= bin_addr_i;
                            fdata_q  <= freq_word_i;
                            state_q  <= W_COMMIT;
                        end else begin
                            bvalid_q <= 1'b1;
                            bresp_q  <= idx_q > COMMIT ? RESP_SLVERR : RESP_OKAY;
                            state_q  <= W_RESP;
                        end
                    end else begin
                        if (aw_hs) begin
                            aw_held_q <= 1'b1;
                            idx_q     <= awidx_i;
                        end
                        if (w_hs) begin
                            w_held_q <= 1'b1;
                            wdata_q  <= wdata_i;
                            wstrb_q  <= wstrb_i;
                        end
                        awready_q <= !aw_held_q && !aw_hs;
                        wready_q  <= !w_held_q && !w_hs;
                    end
                end
                W_COMMIT: if (fwr_ready_i) begin
                    fvalid_q <= 1'b0;
                    bvalid_q <= 1'b1;
                    bresp_q  <= RESP_OKAY;
                    state_q  <= W_RESP;
                end
                W_RESP: if (bready_i) begin
                    bvalid_q  <= 1'b0;
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                    state_q   <= W_IDLE;
                end
                default: state_q <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mix_freq_axil_slave.sv
// mix_freq_axil_slave: AXI4-Lite control slave for the mixer frequency table; holds the
// FREQ_WORD/BIN_ADDR/CTRL/SCRATCH registers and serves reads independently of writes.
module mix_freq_axil_slave
    import mix_freq_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int BIN_AW             = 11
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic                            freq_wr_valid,
    input  logic                            freq_wr_ready,
    output logic [BIN_AW-1:0]               freq_wr_addr,
    output logic [31:0]                     freq_wr_data,
    output logic                            mix_enable
);

    logic [31:0] freq_word_q, bin_addr_q, ctrl_q, scratch_q, rdata_q, rdata_d, reg_wdata;
    logic [1:0]  rresp_q, rresp_d;
    logic [3:0]  reg_wstrb;
    logic [2:0]  reg_idx, ar_idx;
    logic        reg_we, bin_inc, arready_q, rvalid_q, unused_ok;
    rd_state_e   rd_state_q;

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    mix_freq_axil_wr_fsm #(.BIN_AW(BIN_AW)) u_wr_fsm (
        .clk_i       (s00_axi_aclk),
        .rst_ni      (s00_axi_aresetn),
        .awidx_i     (s00_axi_awaddr[4:2]),
        .awvalid_i   (s00_axi_awvalid),
        .awready_o   (s00_axi_awready),
        .wdata_i     (s00_axi_wdata),
        .wstrb_i     (s00_axi_wstrb),
        .wvalid_i    (s00_axi_wvalid),
        .wready_o    (s00_axi_wready),
        .bresp_o     (s00_axi_bresp),
        .bvalid_o    (s00_axi_bvalid),
        .bready_i    (s00_axi_bready),
        .bin_addr_i  (bin_addr_q[BIN_AW-1:0]),
        .freq_word_i (freq_word_q),
        .fwr_valid_o (freq_wr_valid),
        .fwr_ready_i (freq_wr_ready),
        .fwr_addr_o  (freq_wr_addr),
        .fwr_data_o  (freq_wr_data),
        .reg_we_o    (reg_we),
        .reg_idx_o   (reg_idx),
        .reg_wdata_o (reg_wdata),
        .reg_wstrb_o (reg_wstrb),
        .bin_inc_o   (bin_inc)
    );

    assign mix_enable = ctrl_q[CTRL_MIX_EN];

    // BIN_ADDR auto-increment only happens in W_COMMIT, so it never collides with a register write.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            freq_word_q <= '0;
            bin_addr_q  <= '0;
            ctrl_q      <= '0;
            scratch_q   <= '0;
        end else begin
            freq_word_q <= reg_we && reg_idx == FREQ_WORD ? apply_strb(freq_word_q, reg_wdata, reg_wstrb) : freq_word_q;
            ctrl_q      <= reg_we && reg_idx == CTRL ? apply_strb(ctrl_q, reg_wdata, reg_wstrb) : ctrl_q;
            scratch_q   <= reg_we && reg_idx == SCRATCH ? apply_strb(scratch_q, reg_wdata, reg_wstrb) : scratch_q;
            bin_addr_q  <= reg_we && reg_idx == BIN_ADDR ? apply_strb(bin_addr_q, reg_wdata, reg_wstrb) :
                           bin_inc && ctrl_q[CTRL_AUTO_INC] ?
                           {{(32-BIN_AW){1'b0}}, bin_addr_q[BIN_AW-1:0] + BIN_AW'(1)} : bin_addr_q;
        end
    end

    assign ar_idx = s00_axi_araddr[4:2];

    always_comb begin
        rdata_d = ar_idx == FREQ_WORD ? freq_word_q :
                  ar_idx == BIN_ADDR  ? bin_addr_q  :
                  ar_idx == CTRL      ? ctrl_q      :
                  ar_idx == SCRATCH   ? scratch_q   : '0;
        rresp_d = ar_idx > COMMIT ? RESP_SLVERR : RESP_OKAY;
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (arready_q && s00_axi_arvalid) begin
                        rdata_q    <= rdata_d;
                        rresp_q    <= rresp_d;
                        rvalid_q   <= 1'b1;
                        arready_q  <= 1'b0;
                        rd_state_q <= R_VALID;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_VALID: if (s00_axi_rready) begin
                    rvalid_q   <= 1'b0;
                    arready_q  <= 1'b1;
                    rd_state_q <= R_IDLE;
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_mix_freq_axil_slave.sv
// tb_mix_freq_axil_slave: directed tests of the mixer-frequency AXI-Lite slave with
// hand-computed expectations for register access, handshake ordering, COMMIT and reset.
module tb_mix_freq_axil_slave;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [4:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        freq_wr_ready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, freq_wr_valid, mix_enable;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, freq_wr_data;
    logic [10:0] freq_wr_addr;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    mix_freq_axil_slave dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .freq_wr_valid   (freq_wr_valid),
        .freq_wr_ready   (freq_wr_ready),
        .freq_wr_addr    (freq_wr_addr),
        .freq_wr_data    (freq_wr_data),
        .mix_enable      (mix_enable)
    );

    // AW/W launched at cycles aw_at/w_at; bad counts ready-while-busy and unstable B.
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_at, input int w_at, input int bhold,
                             output logic [1:0] r, output int bad);
        int c;
        bit awd, wd, haw, hw;
        c = 0; awd = 0; wd = 0; bad = 0; r = 2'bxx;
        awaddr = a; wdata = d; wstrb = s;
        while (!(awd && wd) && c < 40) begin
            @(negedge clk);
            if ((awd && awready) || (wd && wready)) bad++;
            awvalid = !awd && c >= aw_at;
            wvalid = !wd && c >= w_at;
            haw = awvalid && awready;
            hw = wvalid && wready;
            @(posedge clk);
            awd |= haw; wd |= hw; c++;
        end
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        c = 0;
        while (!bvalid && c < 40) begin
            if (awready || wready) bad++;
            @(negedge clk); c++;
        end
        checks++;
        if (!bvalid) begin
            errors++;
            $display("FAIL write_timeout addr=%h: bvalid=%b required 1", a, bvalid);
            return;
        end
        r = bresp;
        repeat (bhold) begin
            @(negedge clk);
            if (!bvalid || bresp !== r || awready || wready) bad++;
        end
        bready = 1;
        @(negedge clk);
        bready = 0;
        if (bvalid) bad++;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
        int c;
        c = 0; d = 'x; r = 'x;
        @(negedge clk);
        araddr = a; arvalid = 1;
        while (!arready && c < 40) begin @(negedge clk); c++; end
        @(negedge clk);
        arvalid = 0;
        c = 0;
        while (!rvalid && c < 40) begin @(negedge clk); c++; end
        checks++;
        if (!rvalid) begin
            errors++;
            $display("FAIL read_timeout addr=%h: rvalid=%b required 1", a, rvalid);
            return;
        end
        d = rdata; r = rresp;
        rready = 1;
        @(negedge clk);
        rready = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, freq_wr_valid, mix_enable} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000000", {awready, wready, arready, bvalid, rvalid, freq_wr_valid, mix_enable});
        end
        checks++;
        if ({bresp, rresp, rdata} !== 36'h0) begin
            errors++;
            $display("FAIL reset_data: bresp=%b rresp=%b rdata=%h required 0", bresp, rresp, rdata);
        end
        rst_n = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        logic [1:0]  r;
        logic [31:0] d;
        int          bad;
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0, r, bad);
            checks++;
            if (r !== 2'b00 || bad != 0) begin
                errors++;
                $display("FAIL basic_write[%0d]: bresp=%b bad=%0d required 00/0", i, r, bad);
            end
        end
        checks++;
        if (mix_enable !== 1'b1) begin
            errors++;
            $display("FAIL basic_mix_enable: got %b required 1", mix_enable);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4 * i), d, r);
            checks++;
            if (d !== 32'(i + 1) || r !== 2'b00) begin
                errors++;
                $display("FAIL basic_read[%0d]: rdata=%h rresp=%b required %h/00", i, d, r, 32'(i + 1));
            end
        end
    endtask

    task automatic test_ordering;
        logic [1:0]  r;
        logic [31:0] d;
        int          bad;
        logic [4:0]  a_t [3] = '{5'h0C, 5'h00, 5'h04};
        logic [31:0] d_t [3] = '{32'hA5A5_0001, 32'h0000_0055, 32'h0000_0123};
        int          aw_t[3] = '{0, 3, 0};
        int          w_t [3] = '{3, 0, 0};
        int          bh_t[3] = '{0, 0, 5};
        for (int i = 0; i < 3; i++) begin
            axi_write(a_t[i], d_t[i], 4'hF, aw_t[i], w_t[i], bh_t[i], r, bad);
            checks++;
            if (r !== 2'b00 || bad != 0) begin
                errors++;
                $display("FAIL order_write[%0d]: bresp=%b bad=%0d required 00/0", i, r, bad);
            end
        end
        for (int i = 0; i < 3; i++) begin
            axi_read(a_t[i], d, r);
            checks++;
            if (d !== d_t[i] || r !== 2'b00) begin
                errors++;
                $display("FAIL order_read[%0d]: rdata=%h rresp=%b required %h/00", i, d, r, d_t[i]);
            end
        end
    endtask

    task automatic test_commit;
        logic [1:0]  r;
        logic [31:0] d;
        int          bad, c;
        axi_write(5'h00, 32'hDEADBEEF, 4'hF, 0, 0, 0, r, bad);
        axi_write(5'h04, 32'h0000_07FF, 4'hF, 0, 0, 0, r, bad);
        axi_write(5'h08, 32'h0000_0001, 4'hF, 0, 0, 0, r, bad);
        checks++;
        if (mix_enable !== 1'b0) begin
            errors++;
            $display("FAIL commit_mix_off: got %b required 0", mix_enable);
        end
        fork
            axi_write(5'h10, 32'h1, 4'hF, 0, 0, 0, r, bad);
            begin
                c = 0;
                while (!freq_wr_valid && c < 20) begin @(negedge clk); c++; end
                checks++;
                if (freq_wr_valid !== 1'b1 || freq_wr_addr !== 11'h7FF || freq_wr_data !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL commit_start: valid=%b addr=%h data=%h required 1/7ff/deadbeef", freq_wr_valid, freq_wr_addr, freq_wr_data);
                end
                repeat (4) begin
                    @(negedge clk);
                    checks++;
                    if (freq_wr_valid !== 1'b1 || freq_wr_addr !== 11'h7FF || freq_wr_data !== 32'hDEADBEEF || bvalid !== 1'b0) begin
                        errors++;
                        $display("FAIL commit_hold: valid=%b addr=%h data=%h bvalid=%b required 1/7ff/deadbeef/0", freq_wr_valid, freq_wr_addr, freq_wr_data, bvalid);
                    end
                end
                freq_wr_ready = 1;
                @(negedge clk);
                freq_wr_ready = 0;
                checks++;
                if (freq_wr_valid !== 1'b0 || bvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL commit_done: valid=%b bvalid=%b required 0/1", freq_wr_valid, bvalid);
                end
            end
        join
        checks++;
        if (r !== 2'b00 || bad != 0) begin
            errors++;
            $display("FAIL commit_bresp: bresp=%b bad=%0d required 00/0", r, bad);
        end
        axi_read(5'h04, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b00) begin
            errors++;
            $display("FAIL commit_bin_wrap: rdata=%h rresp=%b required 0/00", d, r);
        end
    endtask

    task automatic test_commit_nofire;
        logic [1:0]  r0, r1, r;
        logic [31:0] d;
        int          b0, b1;
        bit          seen;
        seen = 0;
        fork
            begin
                axi_write(5'h10, 32'h0, 4'hF, 0, 0, 0, r0, b0);
                axi_write(5'h10, 32'h1, 4'h0, 0, 0, 0, r1, b1);
            end
            repeat (30) begin
                @(negedge clk);
                if (freq_wr_valid) seen = 1;
            end
        join
        checks++;
        if (r0 !== 2'b00 || r1 !== 2'b00 || b0 != 0 || b1 != 0) begin
            errors++;
            $display("FAIL nofire_bresp: bresp=%b,%b bad=%0d,%0d required 00,00 0,0", r0, r1, b0, b1);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL nofire_valid: freq_wr_valid seen=%b required 0", seen);
        end
        axi_read(5'h10, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b00) begin
            errors++;
            $display("FAIL commit_read: rdata=%h rresp=%b required 0/00", d, r);
        end
        axi_read(5'h04, d, r);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL nofire_bin: rdata=%h required 0", d);
        end
    endtask

    task automatic test_strobe_unmapped;
        logic [1:0]  r;
        logic [31:0] d;
        int          bad;
        axi_write(5'h0C, 32'h11223344, 4'hF, 0, 0, 0, r, bad);
        axi_write(5'h0C, 32'hAABBCCDD, 4'b0100, 0, 0, 0, r, bad);
        axi_read(5'h0C, d, r);
        checks++;
        if (d !== 32'h11BB3344) begin
            errors++;
            $display("FAIL strobe_read: rdata=%h required 11bb3344", d);
        end
        axi_write(5'h18, 32'hFFFFFFFF, 4'hF, 0, 0, 0, r, bad);
        checks++;
        if (r !== 2'b10 || bad != 0) begin
            errors++;
            $display("FAIL unmapped_bresp: bresp=%b bad=%0d required 10/0", r, bad);
        end
        axi_read(5'h18, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin
            errors++;
            $display("FAIL unmapped_read: rdata=%h rresp=%b required 0/10", d, r);
        end
        axi_read(5'h0C, d, r);
        checks++;
        if (d !== 32'h11BB3344) begin
            errors++;
            $display("FAIL unmapped_scratch: rdata=%h required 11bb3344", d);
        end
        axi_read(5'h00, d, r);
        checks++;
        if (d !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL unmapped_freq: rdata=%h required deadbeef", d);
        end
    endtask

    task automatic test_reset_midop;
        logic [1:0]  r;
        logic [31:0] d;
        freq_wr_ready = 0;
        @(negedge clk);
        awaddr = 5'h10; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 5'h00; arvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (freq_wr_valid !== 1'b1 || rvalid !== 1'b1 || rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL midop_busy: fvalid=%b rvalid=%b rdata=%h required 1/1/deadbeef", freq_wr_valid, rvalid, rdata);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({freq_wr_valid, bvalid, rvalid, awready, wready, arready} !== 6'b0) begin
            errors++;
            $display("FAIL midop_async: fvalid/bvalid/rvalid/awready/wready/arready=%b required 000000", {freq_wr_valid, bvalid, rvalid, awready, wready, arready});
        end
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4 * i), d, r);
            checks++;
            if (d !== 32'h0 || r !== 2'b00) begin
                errors++;
                $display("FAIL midop_regs[%0d]: rdata=%h rresp=%b required 0/00", i, d, r);
            end
        end
        checks++;
        if (mix_enable !== 1'b0 || freq_wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL midop_outputs: mix_enable=%b fvalid=%b required 0/0", mix_enable, freq_wr_valid);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_ordering;
        test_commit;
        test_commit_nofire;
        test_strobe_unmapped;
        test_reset_midop;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mix_freq_axil_slave.md
Name: mix_freq_axil_slave

Overview:
- AXI4-Lite responder (slave) that terminates the S00_AXI control interface of the mixer-frequency-set IP.
- Holds four read/write registers and a write-only COMMIT register.
- A COMMIT write launches one valid/ready transfer of {bin address, frequency word} into the mixer's frequency table.
- The B response for a COMMIT is withheld until that transfer completes, so software knows the table entry is written.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; decodes 8 word slots.
- BIN_AW, 11, width of the frequency-table bin address.

Ports:
- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  asynchronous active-low reset
- s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
- s00_axi_awprot  in  3  ignored
- s00_axi_awvalid/awready  in/out  1  AW handshake
- s00_axi_wdata  in  32  write data
- s00_axi_wstrb  in  4  byte strobes
- s00_axi_wvalid/wready  in/out  1  W handshake
- s00_axi_bresp  out  2  OKAY=00, SLVERR=10
- s00_axi_bvalid/bready  out/in  1  B handshake
- s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
- s00_axi_arprot  in  3  ignored
- s00_axi_arvalid/arready  in/out  1  AR handshake
- s00_axi_rdata  out  32  read data
- s00_axi_rresp  out  2  read response
- s00_axi_rvalid/rready  out/in  1  R handshake
- freq_wr_valid  out  1  table write request
- freq_wr_ready  in  1  table accepts the write
- freq_wr_addr  out  BIN_AW  bin index
- freq_wr_data  out  32  frequency word
- mix_enable  out  1  CTRL[1]

Behaviour:
- Register map (word index = addr[4:2]):
  - 0x00 FREQ_WORD: R/W
  - 0x04 BIN_ADDR: R/W, stored 32b
  - 0x08 CTRL: R/W; bit0 auto_inc, bit1 mix_enable
  - 0x0C SCRATCH: R/W
  - 0x10 COMMIT: write-only; reads 0x0
  - 0x14–0x1C: unmapped; SLVERR, no side effects, rdata 0
- Byte strobes apply per byte on all R/W registers. A COMMIT write fires only if wstrb[0]=1 and wdata[0]=1; otherwise it returns OKAY with no action.
- Reset values: all registers 0; awready/wready/arready=0 during reset; bvalid/rvalid/freq_wr_valid=0; bresp/rresp=00; rdata=0; mix_enable=0.
- Write FSM states: W_IDLE, W_COMMIT, W_RESP.
  - W_IDLE: awready=1 until AW is captured; wready=1 until W is captured. AW and W are accepted in either order or in the same cycle; each is buffered.
  - When both are held (cycle N):
    - Normal write: register updates at the N→N+1 edge; bvalid=1 in N+1; go to W_RESP.
    - Firing COMMIT: freq_wr_valid=1 in N+1 with freq_wr_addr=BIN_ADDR[BIN_AW-1:0] and freq_wr_data=FREQ_WORD; go to W_COMMIT.
  - W_COMMIT: hold valid, addr and data stable until freq_wr_ready. On the handshake cycle M:
    - freq_wr_valid drops in M+1.
    - If auto_inc=1, BIN_ADDR <= (BIN_ADDR+1) masked to BIN_AW bits, wrapping 2^BIN_AW-1 → 0.
    - bvalid=1 in M+1; go to W_RESP.
  - W_RESP: hold bvalid and bresp until bready, then return to W_IDLE. awready and wready stay 0 in W_COMMIT and W_RESP.
- Read FSM states: R_IDLE, R_VALID.
  - R_IDLE: arready=1. On AR accepted in cycle N: rdata/rresp register in N+1, rvalid=1; go to R_VALID.
  - R_VALID: hold rdata/rresp/rvalid until rready.
  - rdata is the register value before any write landing at the same edge (read-before-write).
- Read and write paths are fully independent; a read during W_COMMIT is served normally.
- Reset asserted mid-operation: all FSMs return to idle immediately. Any pending freq_wr_valid, bvalid or rvalid drops asynchronously; no half-written register.
- mix_enable = CTRL[1], combinational from the register.

Decomposition:
- Package mix_freq_axil_pkg:
  - register word-index constants (FREQ_WORD=0, BIN_ADDR=1, CTRL=2, SCRATCH=3, COMMIT=4)
  - CTRL bit positions
  - RESP_OKAY/RESP_SLVERR
  - write and read state enums
- One sub-module is natural: mix_freq_axil_wr_fsm (AW/W capture, commit handshake, B channel). The read path and register file stay in the top module.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C, then read back → each read returns the written value, rresp=00, bresp=00; mix_enable=1 after the CTRL write.
- AW presented 3 cycles before W, then W before AW, then both together with bready held low 5 cycles → all three writes land; bvalid held stable until bready; no extra awready/wready while busy.
- FREQ_WORD=0xDEADBEEF, BIN_ADDR=0x7FF, CTRL=0x1; write COMMIT=1 with freq_wr_ready low for 4 cycles → freq_wr_valid held with addr 0x7FF and data 0xDEADBEEF; bvalid appears only the cycle after ready; BIN_ADDR reads 0x0 (wrap).
- COMMIT write with wdata=0x0, then with wstrb=0x0 → OKAY, no freq_wr_valid.
- Write wstrb=0b0100 data 0xAABBCCDD to SCRATCH=0x11223344 → reads 0x11BB3344. Write/read 0x18 → SLVERR, rdata=0, no register change.
- Assert s00_axi_aresetn low while in W_COMMIT and R_VALID → freq_wr_valid, bvalid and rvalid low immediately; after release all registers read 0.
